// File: rtl/time_of_day_counter_pkg.sv
// Shared types and constants for the time-of-day counter.
package time_of_day_counter_pkg;

  // One BCD display digit.
  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX     = 59;
  localparam int MIN_MAX     = 59;
  localparam int HOUR_MAX_24 = 23;
  localparam int HOUR_MAX_12 = 12;
  localparam int HOUR_MIN_12 = 1;

  // True when the two-digit BCD pair encodes the given decimal value.
  function automatic logic bcd_equals(bcd_t tens, bcd_t ones, int value);
    return (tens == bcd_t'(value / 10)) && (ones == bcd_t'(value % 10));
  endfunction

endpackage

// File: rtl/time_of_day_counter_bcd_pair_counter.sv
// Two-digit BCD counter running MIN_VAL..MAX_VAL. Each enabled cycle adds
// one; at MAX_VAL it wraps to MIN_VAL and raises carry for that cycle.
// clear loads MIN_VAL and takes priority over enable (no carry).
module bcd_pair_counter
  import time_of_day_counter_pkg::*;
#(
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 59,
  parameter int RESET_VAL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry
);

  localparam bcd_t MIN_TENS = bcd_t'(MIN_VAL / 10);
  localparam bcd_t MIN_ONES = bcd_t'(MIN_VAL % 10);
  localparam bcd_t RST_TENS = bcd_t'(RESET_VAL / 10);
  localparam bcd_t RST_ONES = bcd_t'(RESET_VAL % 10);

  logic at_max;

  assign at_max = bcd_equals(tens, ones, MAX_VAL);
  assign carry  = enable && at_max && !clear;

  // Advance the digit pair, wrapping from MAX_VAL back to MIN_VAL.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block order.
    if (rst) begin
      tens <= RST_TENS;
      ones <= RST_ONES;
    end else if (clear) begin
      tens <= MIN_TENS;
      ones <= MIN_ONES;
    end else if (enable) begin
      if (at_max) begin
        tens <= MIN_TENS;
        ones <= MIN_ONES;
      end else if (ones == bcd_t'(9)) begin
        tens <= tens + bcd_t'(1);
        ones <= '0;
      end else begin
        ones <= ones + bcd_t'(1);
      end
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// Time-of-day clock: prescaler divides clk down to one-second steps that
// ripple through seconds, minutes and hours BCD pairs. Two set buttons
// (synchronized, rising-edge detected) bump minutes or hours.
// Build option: define TIME_12H_EN for a 12-hour display (01..12 plus pm);
// otherwise hours run 00..23 and pm is tied low.
module time_of_day_counter
  import time_of_day_counter_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] hour_tens,
  output logic       sec_tick,
  output logic       colon,
  output logic       pm
);

`ifdef TIME_12H_EN
  localparam bit TWELVE_HOUR = 1'b1;
`else
  localparam bit TWELVE_HOUR = 1'b0;
`endif

  localparam int HOUR_MIN   = TWELVE_HOUR ? HOUR_MIN_12 : 0;
  localparam int HOUR_MAX   = TWELVE_HOUR ? HOUR_MAX_12 : HOUR_MAX_24;
  localparam int HOUR_RESET = TWELVE_HOUR ? HOUR_MAX_12 : 0;

  localparam int               PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2);

  logic [PRE_W-1:0] prescaler;
  logic [1:0]       min_sync;
  logic [1:0]       hour_sync;
  logic             min_prev;
  logic             hour_prev;
  logic             min_set;
  logic             hour_set;
  logic             sec_advance;
  logic             sec_carry;
  logic             min_carry;
  logic             min_en;
  logic             hour_en;
  logic             day_wrap_unused;

  // One action per synchronized rising edge: a held button acts once.
  assign min_set  = min_sync[1] && !min_prev;
  assign hour_set = hour_sync[1] && !hour_prev;

  assign sec_advance = run && (prescaler == PRE_LAST);

  // Setting minutes is a direct bump and must not carry into hours; a
  // coincident seconds rollover merges into the same single increment.
  assign min_en  = sec_carry || min_set;
  assign hour_en = hour_set || (min_carry && !min_set);

  assign colon = !run || (prescaler < PRE_HALF);

  // Two-flop synchronizers plus the previous-level flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_sync  <= '0;
      hour_sync <= '0;
      min_prev  <= 1'b0;
      hour_prev <= 1'b0;
    end else begin
      min_sync  <= {min_sync[0], inc_min};
      hour_sync <= {hour_sync[0], inc_hour};
      min_prev  <= min_sync[1];
      hour_prev <= hour_sync[1];
    end
  end

  // Divide clk to one-second steps; a minute set restarts the second.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (min_set) begin
      prescaler <= '0;
    end else if (run) begin
      prescaler <= sec_advance ? '0 : prescaler + PRE_W'(1);
    end
  end

  // Registered so the pulse lines up with the freshly updated digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sec_tick <= 1'b0;
    else       sec_tick <= sec_advance;
  end

  bcd_pair_counter #(
    .MIN_VAL  (0),
    .MAX_VAL  (SEC_MAX),
    .RESET_VAL(0)
  ) u_seconds (
    .clk   (clk),
    .rst   (reset),
    .clear (min_set),
    .enable(sec_advance),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (sec_carry)
  );

  bcd_pair_counter #(
    .MIN_VAL  (0),
    .MAX_VAL  (MIN_MAX),
    .RESET_VAL(0)
  ) u_minutes (
    .clk   (clk),
    .rst   (reset),
    .clear (1'b0),
    .enable(min_en),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (min_carry)
  );

  // The hour wrap marks the day boundary; nothing downstream consumes it.
  bcd_pair_counter #(
    .MIN_VAL  (HOUR_MIN),
    .MAX_VAL  (HOUR_MAX),
    .RESET_VAL(HOUR_RESET)
  ) u_hours (
    .clk   (clk),
    .rst   (reset),
    .clear (1'b0),
    .enable(hour_en),
    .tens  (hour_tens),
    .ones  (hour_ones),
    .carry (day_wrap_unused)
  );

`ifdef TIME_12H_EN
  // Flip the afternoon flag on the 11 -> 12 step, from counting or setting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pm <= 1'b0;
    end else if (hour_en && bcd_equals(hour_tens, hour_ones, HOUR_MAX_12 - 1)) begin
      pm <= !pm;
    end
  end
`else
  assign pm = 1'b0;
`endif

endmodule
